// File: rtl/syst_apb_sequencer_pkg.sv
// Shared types and register map for the systolic-array APB job sequencer.
package syst_pkg;

  localparam logic [31:0] REG_DATA    = 32'd0;
  localparam logic [31:0] REG_RESULT  = 32'd4;
  localparam logic [31:0] REG_WEIGHT0 = 32'd8;
  localparam logic [31:0] ADDR_STEP   = 32'd4;
  localparam logic [7:0]  N_WEIGHT    = 8'd4;
  localparam int          TIMEOUT_CYC = 64;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_ACCESS,
    S_DRAIN,
    S_RSETUP,
    S_RACCESS,
    S_PUSH,
    S_DONE
  } seq_state_t;

  function automatic logic [31:0] weight_addr(input logic [7:0] idx);
    return REG_WEIGHT0 + ADDR_STEP * {24'd0, idx};
  endfunction

endpackage

// File: rtl/syst_apb_sequencer_if.sv
// APB bus bundle between the job sequencer (master) and the systolic-array slave.
interface syst_apb_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       m_adr_o;
  logic [DATA_W-1:0] m_dat_o;
  logic [DATA_W-1:0] m_dat_i;
  logic              m_sel_o;
  logic              m_enable_o;
  logic              m_we_o;
  logic              m_ready_i;

  modport master (
    output m_adr_o, m_dat_o, m_sel_o, m_enable_o, m_we_o,
    input  m_dat_i, m_ready_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_sel_o, m_enable_o, m_we_o,
    output m_dat_i, m_ready_i
  );
endinterface

// File: rtl/syst_apb_sequencer_apb_master_phase.sv
// One APB transfer (setup then access) per request; optional access watchdog
// enabled by SYST_SEQ_TIMEOUT_EN.
module apb_master_phase
  import syst_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic req_we,
  input  logic ready,
  output logic sel,
  output logic enable,
  output logic we,
  output logic xfer_done,
  output logic timeout
);

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  phase_t ph_q, ph_nx;
  logic   we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= PH_IDLE;
      we_q <= 1'b0;
    end else begin
      ph_q <= ph_nx;
      if (req)
        we_q <= req_we;
      else if (ph_nx == PH_IDLE)
        we_q <= 1'b0;
    end
  end

  always_comb begin
    ph_nx     = ph_q;
    xfer_done = 1'b0;
    case (ph_q)
      PH_IDLE:   if (req) ph_nx = PH_SETUP;
      PH_SETUP:  ph_nx = PH_ACCESS;
      PH_ACCESS: begin
        if (ready) begin
          xfer_done = 1'b1;
          ph_nx     = PH_IDLE;
        end else if (timeout) begin
          ph_nx = PH_IDLE;
        end
      end
      default:   ph_nx = PH_IDLE;
    endcase
  end

  assign sel    = (ph_q != PH_IDLE);
  assign enable = (ph_q == PH_ACCESS);
  assign we     = we_q;

`ifdef SYST_SEQ_TIMEOUT_EN
  // Reloads outside ACCESS; reaching zero on a not-ready cycle is the 64th wait cycle.
  logic [7:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_q <= 8'(TIMEOUT_CYC - 1);
    else if (ph_q == PH_ACCESS)
      wd_q <= wd_q - 8'd1;
    else
      wd_q <= 8'(TIMEOUT_CYC - 1);
  end

  assign timeout = (ph_q == PH_ACCESS) && !ready && (wd_q == 8'd0);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/syst_apb_sequencer.sv
// Sequences one systolic-array job: weight/data writes, drain, result reads.
// Optional access watchdog enabled by SYST_SEQ_TIMEOUT_EN.
module syst_apb_sequencer
  import syst_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DRAIN_CYC = 12
) (
  input  logic                 p_clk_i,
  input  logic                 p_rst_i,
  input  logic                 start_i,
  input  logic [7:0]           cfg_n_data_i,
  input  logic [7:0]           cfg_n_res_i,
  input  logic                 src_valid_i,
  input  logic [DATA_W-1:0]    src_data_i,
  output logic                 src_ready_o,
  syst_apb_sequencer_if.master bus,
  output logic                 res_valid_o,
  output logic [DATA_W-1:0]    res_data_o,
  input  logic                 res_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  seq_state_t        state_q, state_nx;
  logic [7:0]        n_data_q, n_res_q;
  logic [7:0]        widx_q, didx_q, ridx_q, drain_q;
  logic [31:0]       adr_q;
  logic [DATA_W-1:0] dat_q, res_q;
  logic              is_weight, last_src, last_res;
  logic              req, req_we, xfer_done, timeout;
  logic              sel, enable, we;

  assign is_weight = (widx_q < N_WEIGHT);
  assign last_src  = is_weight ? ((widx_q == N_WEIGHT - 8'd1) && (n_data_q == 8'd0))
                               : (({1'b0, didx_q} + 9'd1) == {1'b0, n_data_q});
  assign last_res  = (({1'b0, ridx_q} + 9'd1) >= {1'b0, n_res_q});

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_nx = S_FETCH;
      S_FETCH:   if (src_valid_i) state_nx = S_SETUP;
      S_SETUP:   state_nx = S_ACCESS;
      S_ACCESS: begin
        if (xfer_done) begin
          if (!last_src)
            state_nx = S_FETCH;
          else if (n_res_q == 8'd0)
            state_nx = S_DONE;
          else
            state_nx = S_DRAIN;
        end else if (timeout) begin
          state_nx = S_IDLE;
        end
      end
      S_DRAIN:   if (drain_q == 8'd0) state_nx = S_RSETUP;
      S_RSETUP:  state_nx = S_RACCESS;
      S_RACCESS: begin
        if (xfer_done)
          state_nx = S_PUSH;
        else if (timeout)
          state_nx = S_IDLE;
      end
      S_PUSH:    if (res_ready_i) state_nx = last_res ? S_DONE : S_RSETUP;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // The phase engine enters SETUP on the same edge as the FSM does.
  assign req    = (state_nx == S_SETUP) || (state_nx == S_RSETUP);
  assign req_we = (state_nx == S_SETUP);

  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      state_q  <= S_IDLE;
      n_data_q <= 8'd0;
      n_res_q  <= 8'd0;
      widx_q   <= 8'd0;
      didx_q   <= 8'd0;
      ridx_q   <= 8'd0;
      drain_q  <= 8'd0;
      adr_q    <= 32'd0;
      dat_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_nx;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_data_q <= cfg_n_data_i;
            n_res_q  <= cfg_n_res_i;
            widx_q   <= 8'd0;
            didx_q   <= 8'd0;
            ridx_q   <= 8'd0;
          end
        end
        S_FETCH: begin
          if (src_valid_i) begin
            dat_q <= src_data_i;
            adr_q <= is_weight ? weight_addr(widx_q) : REG_DATA;
          end
        end
        S_ACCESS: begin
          if (xfer_done) begin
            if (is_weight)
              widx_q <= widx_q + 8'd1;
            else
              didx_q <= didx_q + 8'd1;
            drain_q <= 8'(DRAIN_CYC - 1);
          end
        end
        S_DRAIN: begin
          if (drain_q == 8'd0)
            adr_q <= REG_RESULT;
          else
            drain_q <= drain_q - 8'd1;
        end
        S_RACCESS: if (xfer_done) res_q <= bus.m_dat_i;
        S_PUSH:    if (res_ready_i) ridx_q <= ridx_q + 8'd1;
        default: ;
      endcase
    end
  end

  apb_master_phase u_phase (
    .clk       (p_clk_i),
    .rst_n     (p_rst_i),
    .req       (req),
    .req_we    (req_we),
    .ready     (bus.m_ready_i),
    .sel       (sel),
    .enable    (enable),
    .we        (we),
    .xfer_done (xfer_done),
    .timeout   (timeout)
  );

  assign bus.m_adr_o    = adr_q;
  assign bus.m_dat_o    = dat_q;
  assign bus.m_sel_o    = sel;
  assign bus.m_enable_o = enable;
  assign bus.m_we_o     = we;

  assign src_ready_o = (state_q == S_FETCH);
  assign res_valid_o = (state_q == S_PUSH);
  assign res_data_o  = res_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

`ifdef SYST_SEQ_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i)
      err_q <= 1'b0;
    else
      err_q <= timeout;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_syst_apb_sequencer.sv
// Self-checking bench for syst_apb_sequencer: slave/source/sink models plus a
// transaction-level expectation of every APB transfer and result word.
module tb_syst_apb_sequencer;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_nd, cfg_nr;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        busy, done, err;

  syst_apb_sequencer_if #(.DATA_W(32)) bus ();

  syst_apb_sequencer #(.DATA_W(32), .DRAIN_CYC(12)) dut (
    .p_clk_i      (clk),
    .p_rst_i      (rst_n),
    .start_i      (start),
    .cfg_n_data_i (cfg_nd),
    .cfg_n_res_i  (cfg_nr),
    .src_valid_i  (src_valid),
    .src_data_i   (src_data),
    .src_ready_o  (src_ready),
    .bus          (bus),
    .res_valid_o  (res_valid),
    .res_data_o   (res_data),
    .res_ready_i  (res_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  wr_t         exp_wr[$];
  logic [31:0] exp_res[$];
  logic [31:0] src_q[$];
  logic [31:0] nominal[8] = '{32'h01050501, 32'h02050602, 32'h03050703, 32'h04050804,
                              32'h01020304, 32'h05060708, 32'h09080706, 32'h05050505};

  int ws_lo = 0, ws_hi = 0, gap_lo = 0, gap_hi = 0, st_lo = 0, st_hi = 0;
  int wr_cnt, rd_cnt, res_cnt, done_cnt, err_cnt, idle_cnt, stall_left;
  int acc_cnt = 0, acc_wait = 0, acc_len_last = 0, gap_left = 0;
  bit hang = 0, rd_started = 0, pend_accept = 0, res_held = 0;
  logic [31:0] su_adr, su_dat, res_hold;
  logic        su_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_sel"},       64'(bus.m_sel_o),    64'd0);
    chk({pfx, "_enable"},    64'(bus.m_enable_o), 64'd0);
    chk({pfx, "_we"},        64'(bus.m_we_o),     64'd0);
    chk({pfx, "_adr"},       64'(bus.m_adr_o),    64'd0);
    chk({pfx, "_dat"},       64'(bus.m_dat_o),    64'd0);
    chk({pfx, "_src_ready"}, 64'(src_ready),      64'd0);
    chk({pfx, "_res_valid"}, 64'(res_valid),      64'd0);
    chk({pfx, "_res_data"},  64'(res_data),       64'd0);
    chk({pfx, "_busy"},      64'(busy),           64'd0);
    chk({pfx, "_done"},      64'(done),           64'd0);
    chk({pfx, "_err"},       64'(err),            64'd0);
  endtask

  // Source model: offers queued words, optional gap after each accepted word.
  initial begin
    src_valid = 1'b0;
    src_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        src_valid   = 1'b0;
        pend_accept = 1'b0;
        continue;
      end
      if (pend_accept) begin
        if (src_q.size() > 0) src_q.delete(0);
        gap_left    = $urandom_range(gap_hi, gap_lo);
        pend_accept = 1'b0;
      end
      if (gap_left > 0) begin
        src_valid = 1'b0;
        gap_left--;
      end else if (src_q.size() > 0) begin
        src_valid = 1'b1;
        src_data  = src_q[0];
      end else begin
        src_valid = 1'b0;
        src_data  = $urandom;
      end
      pend_accept = src_valid && src_ready;
    end
  end

  // APB slave + result sink + protocol monitor.
  initial begin
    bus.m_ready_i = 1'b0;
    bus.m_dat_i   = 32'd0;
    res_ready     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.m_ready_i = 1'b0;
        res_ready     = 1'b0;
        acc_cnt       = 0;
        res_held      = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;

      if (bus.m_sel_o && !bus.m_enable_o) begin
        su_adr   = bus.m_adr_o;
        su_dat   = bus.m_dat_o;
        su_we    = bus.m_we_o;
        acc_wait = $urandom_range(ws_hi, ws_lo);
        if (!su_we && !rd_started) begin
          chk("drain_idle_cycles", 64'(idle_cnt), 64'd12);
          rd_started = 1'b1;
        end
      end
      if (!bus.m_sel_o) idle_cnt++;

      if (bus.m_sel_o && bus.m_enable_o) begin
        chk("acc_adr_stable", 64'(bus.m_adr_o), 64'(su_adr));
        chk("acc_we_stable",  64'(bus.m_we_o),  64'(su_we));
        if (su_we) chk("acc_dat_stable", 64'(bus.m_dat_o), 64'(su_dat));
        acc_cnt++;
        if (!hang && acc_cnt > acc_wait) begin
          bus.m_ready_i = 1'b1;
          if (exp_wr.size() > 0) begin
            chk("wr_we",  64'(bus.m_we_o),  64'd1);
            chk("wr_adr", 64'(bus.m_adr_o), 64'(exp_wr[0].adr));
            chk("wr_dat", 64'(bus.m_dat_o), 64'(exp_wr[0].dat));
            exp_wr.delete(0);
            wr_cnt++;
            idle_cnt = 0;
          end else begin
            chk("rd_we",  64'(bus.m_we_o),  64'd0);
            chk("rd_adr", 64'(bus.m_adr_o), 64'd4);
            bus.m_dat_i = $urandom;
            exp_res.push_back(bus.m_dat_i);
            rd_cnt++;
          end
        end else begin
          bus.m_ready_i = 1'b0;
        end
      end else begin
        if (acc_cnt > 0) acc_len_last = acc_cnt;
        acc_cnt       = 0;
        bus.m_ready_i = 1'b0;
      end

      if (res_valid) begin
        chk("no_read_while_pending", 64'(bus.m_sel_o), 64'd0);
        if (res_held) chk("res_data_held", 64'(res_data), 64'(res_hold));
        res_hold = res_data;
        res_held = 1'b1;
        if (stall_left > 0) begin
          stall_left--;
          res_ready = 1'b0;
        end else begin
          res_ready = 1'b1;
          if (exp_res.size() > 0) chk("res_data", 64'(res_data), 64'(exp_res.pop_front()));
          res_cnt++;
          res_held   = 1'b0;
          stall_left = $urandom_range(st_hi, st_lo);
        end
      end else begin
        res_ready = 1'($urandom_range(1, 0));
        res_held  = 1'b0;
      end
    end
  end

  task automatic job_start(input int nd, input int nr, input bit directed);
    wr_t e;
    exp_wr.delete();
    exp_res.delete();
    src_q.delete();
    wr_cnt = 0; rd_cnt = 0; res_cnt = 0; done_cnt = 0; err_cnt = 0;
    idle_cnt = 0; rd_started = 1'b0;
    stall_left = $urandom_range(st_hi, st_lo);
    for (int i = 0; i < 4 + nd; i++) begin
      e.dat = directed ? nominal[i] : $urandom;
      e.adr = (i < 4) ? 32'(8 + 4 * i) : 32'd0;
      src_q.push_back(e.dat);
      exp_wr.push_back(e);
    end
    @(negedge clk);
    start  = 1'b1;
    cfg_nd = 8'(nd);
    cfg_nr = 8'(nr);
    @(negedge clk);
    start  = 1'b0;
    cfg_nd = 8'($urandom);
    cfg_nr = 8'($urandom);
  endtask

  task automatic job_finish(input int nd, input int nr);
    int cyc = 0;
    while (done_cnt == 0 && err_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("done_once",     64'(done_cnt),      64'd1);
    chk("err_none",      64'(err_cnt),       64'd0);
    chk("write_count",   64'(wr_cnt),        64'(4 + nd));
    chk("read_count",    64'(rd_cnt),        64'(nr));
    chk("result_count",  64'(res_cnt),       64'(nr));
    chk("writes_left",   64'(exp_wr.size()), 64'd0);
    chk("busy_after",    64'(busy),          64'd0);
  endtask

  task automatic set_ranges(input int w0, input int w1, input int g0, input int g1,
                            input int s0, input int s1);
    ws_lo = w0; ws_hi = w1; gap_lo = g0; gap_hi = g1; st_lo = s0; st_hi = s1;
  endtask

  initial begin
    int nd, nr, cyc;
    bit seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    cfg_nd = 8'd0;
    cfg_nr = 8'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal job with the fixed word list, slave ready on first access cycle.
    set_ranges(0, 0, 0, 0, 0, 0);
    job_start(4, 7, 1'b1);
    job_finish(4, 7);

    // Three wait states on every transfer.
    set_ranges(3, 3, 0, 0, 0, 0);
    job_start(4, 3, 1'b0);
    job_finish(4, 3);

    // Five-cycle source gaps between words.
    set_ranges(0, 0, 5, 5, 0, 0);
    job_start(3, 2, 1'b0);
    job_finish(3, 2);

    // Ten-cycle result stalls.
    set_ranges(0, 1, 0, 0, 10, 10);
    job_start(2, 3, 1'b0);
    job_finish(2, 3);

    // Empty data and read phases, plus a start pulse while busy.
    set_ranges(0, 0, 0, 0, 0, 0);
    job_start(0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_mid_job", 64'(busy), 64'd1);
    start  = 1'b1;
    cfg_nd = 8'd5;
    cfg_nr = 8'd5;
    @(negedge clk);
    start = 1'b0;
    job_finish(0, 0);

    // Reads after weights only.
    set_ranges(0, 2, 0, 1, 0, 2);
    job_start(0, 3, 1'b0);
    job_finish(0, 3);

    // Maximum counts.
    set_ranges(0, 0, 0, 0, 0, 0);
    job_start(255, 255, 1'b0);
    job_finish(255, 255);

    for (int j = 0; j < 6; j++) begin
      set_ranges(0, 3, 0, 3, 0, 4);
      nd = $urandom_range(12, 0);
      nr = $urandom_range(8, 0);
      job_start(nd, nr, 1'b0);
      job_finish(nd, nr);
    end

    // Asynchronous reset in the middle of a data access.
    set_ranges(3, 3, 0, 0, 0, 0);
    job_start(4, 2, 1'b0);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.m_sel_o && bus.m_enable_o && bus.m_we_o && bus.m_adr_o == 32'd0) seen = 1'b1;
    end
    chk("reached_data_access", 64'(seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    src_q.delete();
    exp_wr.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_ranges(0, 1, 0, 1, 0, 1);
    job_start(1, 1, 1'b0);
    job_finish(1, 1);

`ifdef SYST_SEQ_TIMEOUT_EN
    set_ranges(0, 0, 0, 0, 0, 0);
    hang = 1'b1;
    job_start(1, 1, 1'b0);
    cyc = 0;
    while (err_cnt == 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("timeout_err_once",   64'(err_cnt),      64'd1);
    chk("timeout_no_done",    64'(done_cnt),     64'd0);
    chk("timeout_access_len", 64'(acc_len_last), 64'd64);
    chk("timeout_busy_clear", 64'(busy),         64'd0);
    hang = 1'b0;
    src_q.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
